// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between IF and DM ports.
// DM has priority; IF is forced through after MAX_WAIT consecutive denials.
// Ports: clk/rst (async active-low); if_* instruction-fetch read port;
// dm_* data port (dm_we 00 rd,01 byte,10 half,11 word); mem_* SRAM side;
// perf_* counters, built only when ARB_PERF_CNT_EN is defined (else tied 0).
module unified_mem_arbiter #(
  parameter int MEM_BYTES = 65536,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [1:0]  dm_we,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] perf_conflicts,
  output logic [31:0] perf_if_stall
);
  localparam logic [31:0] LP_LAST = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  LP_MAX  = 4'(MAX_WAIT);
  localparam logic [1:0]  OWN_NONE = 2'd0;
  localparam logic [1:0]  OWN_IF   = 2'd1;
  localparam logic [1:0]  OWN_DM   = 2'd2;
  logic [3:0]  r_wait_cnt;
  logic [1:0]  r_owner;
  logic        r_oor;
  logic [31:0] r_if_hold;
  logic [31:0] r_dm_hold;
  logic        w_dm_win;
  logic        w_if_win;
  logic        w_oor;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  // Grants are suppressed while reset is held so every output reads 0.
  assign w_dm_win  = rst && dm_req && !(if_req && r_wait_cnt == LP_MAX);
  assign w_if_win  = rst && if_req && !w_dm_win;
  assign w_addr    = w_dm_win ? dm_addr : w_if_win ? if_addr : 32'd0;
  assign w_oor     = w_addr > LP_LAST;
  assign if_gnt    = w_if_win;
  assign dm_gnt    = w_dm_win;
  assign mem_en    = (w_dm_win || w_if_win) && !w_oor;
  assign mem_we    = w_dm_win ? dm_we : 2'b00;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_dm_win ? dm_wdata : 32'd0;
  assign w_rdata   = r_oor ? 32'hFFFF_FFFF : mem_rdata;
  assign if_rvalid = r_owner == OWN_IF;
  assign dm_rvalid = r_owner == OWN_DM;
  assign if_rdata  = if_rvalid ? w_rdata : r_if_hold;
  assign dm_rdata  = dm_rvalid ? w_rdata : r_dm_hold;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
      r_owner    <= OWN_NONE;
      r_oor      <= 1'b0;
      r_if_hold  <= 32'd0;
      r_dm_hold  <= 32'd0;
    end else begin
      r_wait_cnt <= (!if_req || w_if_win) ? 4'd0 :
                    (r_wait_cnt == LP_MAX) ? r_wait_cnt : r_wait_cnt + 4'd1;
      // Only reads claim the response slot; writes leave it empty.
      r_owner    <= w_if_win ? OWN_IF : (w_dm_win && dm_we == 2'b00) ? OWN_DM : OWN_NONE;
      r_oor      <= w_oor;
      if (if_rvalid) r_if_hold <= w_rdata;
      if (dm_rvalid) r_dm_hold <= w_rdata;
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_conf;
  logic [31:0] r_perf_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_conf  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      r_perf_conf  <= r_perf_conf + 32'(if_req && dm_req);
      r_perf_stall <= r_perf_stall + 32'(if_req && !w_if_win);
    end
  end
  assign perf_conflicts = r_perf_conf;
  assign perf_if_stall  = r_perf_stall;
`else
  assign perf_conflicts = 32'd0;
  assign perf_if_stall  = 32'd0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed plus random checks against a behavioural model.
module tb_unified_mem_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [1:0] dm_we = '0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, perf_conflicts, perf_if_stall;
  logic [1:0] mem_we;
  logic [31:0] mem_rdata = '0;
  logic [7:0] sram [0:65535];
  logic [7:0] gmem [0:65535];
  int vectors = 0, miscompares = 0;
  int streak = 0, own = 0;
  logic [31:0] pend = '0, hold_if = '0, hold_dm = '0, pc = '0, ps = '0;

  unified_mem_arbiter #(.MEM_BYTES(65536), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_conflicts(perf_conflicts), .perf_if_stall(perf_if_stall)
  );

  always #5 clk = ~clk;

  // SRAM: byte-addressed, little-endian, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 2'b00)
        mem_rdata <= {sram[mem_addr[15:0] + 16'd3], sram[mem_addr[15:0] + 16'd2],
                      sram[mem_addr[15:0] + 16'd1], sram[mem_addr[15:0]]};
      else begin
        sram[mem_addr[15:0]] <= mem_wdata[7:0];
        if (mem_we[1]) sram[mem_addr[15:0] + 16'd1] <= mem_wdata[15:8];
        if (mem_we == 2'b11) begin
          sram[mem_addr[15:0] + 16'd2] <= mem_wdata[23:16];
          sram[mem_addr[15:0] + 16'd3] <= mem_wdata[31:24];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] gread(input logic [31:0] a);
    int i;
    i = int'(a[15:0]);
    return {gmem[i + 3], gmem[i + 2], gmem[i + 1], gmem[i]};
  endfunction

  task automatic gwrite(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int i;
    i = int'(a[15:0]);
    gmem[i] = d[7:0];
    if (w[1]) gmem[i + 1] = d[15:8];
    if (w == 2'b11) begin
      gmem[i + 2] = d[23:16];
      gmem[i + 3] = d[31:24];
    end
  endtask

  task automatic model_reset();
    streak = 0; own = 0; pend = '0; hold_if = '0; hold_dm = '0; pc = '0; ps = '0;
  endtask

  // One clock: drive at negedge, compare everything against the model, advance the model.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [1:0] dw, input logic [31:0] wd);
    logic eg_dm, eg_if, inr;
    logic [31:0] a;
    @(negedge clk);
    if_req = ir; if_addr = ia; dm_req = dr; dm_addr = da; dm_we = dw; dm_wdata = wd;
    #1;
    eg_dm = dr && !(ir && streak == MAX_WAIT);
    eg_if = ir && !eg_dm;
    a = eg_dm ? da : ia;
    inr = a <= 32'hFFFC;
    chk("if_gnt", 32'(if_gnt), 32'(eg_if));
    chk("dm_gnt", 32'(dm_gnt), 32'(eg_dm));
    chk("mem_en", 32'(mem_en), 32'((eg_if || eg_dm) && inr));
    if (eg_if || eg_dm) begin
      chk("mem_addr", mem_addr, a);
      chk("mem_we", 32'(mem_we), eg_dm ? 32'(dw) : 32'd0);
    end
    if (eg_dm) chk("mem_wdata", mem_wdata, wd);
    chk("if_rvalid", 32'(if_rvalid), 32'(own == 1));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(own == 2));
    chk("if_rdata", if_rdata, own == 1 ? pend : hold_if);
    chk("dm_rdata", dm_rdata, own == 2 ? pend : hold_dm);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflicts", perf_conflicts, pc);
    chk("perf_if_stall", perf_if_stall, ps);
`else
    chk("perf_conflicts", perf_conflicts, 32'd0);
    chk("perf_if_stall", perf_if_stall, 32'd0);
`endif
    if (own == 1) hold_if = pend;
    if (own == 2) hold_dm = pend;
    own = eg_if ? 1 : (eg_dm && dw == 2'b00) ? 2 : 0;
    if (own != 0) pend = inr ? gread(a) : 32'hFFFF_FFFF;
    if (eg_dm && dw != 2'b00 && inr) gwrite(a, dw, wd);
    if (ir && dr) pc = pc + 1;
    if (ir && !eg_if) ps = ps + 1;
    streak = (ir && !eg_if) ? (streak < MAX_WAIT ? streak + 1 : streak) : 0;
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 32'd0);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = 32'h1000 + $urandom_range(0, 63);
    case ($urandom_range(0, 15))
      0: r = 32'hFFFD + $urandom_range(0, 2);
      1: r = 32'h0001_0000 + $urandom_range(0, 255);
      2: r = 32'hFFFF_FFFC;
      3: r = 32'hFFFC;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [9:0] pat;
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'($urandom);
      gmem[i] = sram[i];
    end
    {sram[19], sram[18], sram[17], sram[16]} = 32'h0050_0093;
    {gmem[19], gmem[18], gmem[17], gmem[16]} = 32'h0050_0093;
    // Outputs stay 0 while reset is held, even with requests present.
    repeat (2) @(negedge clk);
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h20;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // IF-only fetch right after reset.
    cycle(1'b1, 32'h10, 1'b0, 32'd0, 2'b00, 32'd0);
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    idle();
    chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_dm_rvalid", 32'(dm_rvalid), 32'd0);
    // Word write then read-back.
    cycle(1'b0, 32'd0, 1'b1, 32'h1110, 2'b11, 32'hDEAD_BEEF);
    chk("t3_dm_gnt", 32'(dm_gnt), 32'd1);
    cycle(1'b0, 32'd0, 1'b1, 32'h1110, 2'b00, 32'd0);
    chk("t3_no_rvalid_after_write", 32'(dm_rvalid), 32'd0);
    idle();
    chk("t3_dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("t3_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    // Out-of-range read and write.
    cycle(1'b0, 32'd0, 1'b1, 32'hFFFD, 2'b00, 32'd0);
    chk("t4_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("t4_mem_en", 32'(mem_en), 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 32'hFFFD, 2'b11, 32'h1234_5678);
    chk("t4_oor_rvalid", 32'(dm_rvalid), 32'd1);
    chk("t4_oor_rdata", dm_rdata, 32'hFFFF_FFFF);
    chk("t4_wr_mem_en", 32'(mem_en), 32'd0);
    idle();
    chk("t4_wr_no_rvalid", 32'(dm_rvalid), 32'd0);
    // Reset asserted while an IF read is in flight.
    cycle(1'b1, 32'h20, 1'b0, 32'd0, 2'b00, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    if_req = 1'b0;
    #1;
    chk("t5_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t5_if_rdata", if_rdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("t5_no_stale_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
    idle();
    // Contention: DM wins four times, IF forced on the fifth.
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h20, 1'b1, 32'h110C, 2'b00, 32'd0);
      chk("t2_if_gnt_pattern", 32'(if_gnt), 32'(pat[i]));
    end
    idle();
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_conflicts", perf_conflicts, 32'd10);
    chk("t6_perf_if_stall", perf_if_stall, 32'd8);
`else
    chk("t6_perf_conflicts_off", perf_conflicts, 32'd0);
    chk("t6_perf_if_stall_off", perf_if_stall, 32'd0);
`endif
    // Random traffic.
    for (int n = 0; n < 1500; n++)
      cycle(($urandom_range(0, 3) != 0), raddr(), ($urandom_range(0, 3) != 0), raddr(),
            2'($urandom_range(0, 3)), $urandom);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
